// File: rtl/serial_word_receiver_if.sv
// Bus between the edge-detector/sync stage and the serial word receiver.
// The master drives bit strobes, chip select and data; the receiver returns assembled words.
interface serial_word_receiver_if #(
    parameter int WORD_SIZE = 8
);
    logic                 sample_edge;
    logic                 cs;
    logic                 data_in;
    logic [WORD_SIZE-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output sample_edge, cs, data_in,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  sample_edge, cs, data_in,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Assembles serial bits, strobed by single-cycle sample_edge pulses inside a chip-select
// frame, into parallel words; flags frames that end with a partial word.
module serial_word_receiver #(
    parameter int WORD_SIZE     = 8,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit CS_ACTIVE_LOW = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   n_reset,
    serial_word_receiver_if.slave  bus
);
    localparam int CNT_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 cs_act;
    logic [WORD_SIZE-1:0] shifted;

    assign cs_act = CS_ACTIVE_LOW ? ~bus.cs : bus.cs;

    // Shift register contents with the current data_in bit folded in.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WORD_SIZE-2:0], bus.data_in};
        end else begin
            shifted = {bus.data_in, shift_q[WORD_SIZE-1:1]};
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Bits coinciding with cs assertion are deliberately dropped.
                count_d = '0;
                if (cs_act) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!cs_act) begin
                    state_d = IDLE;
                    count_d = '0;
                    shift_d = '0;
                    err_d   = (count_q != '0);
                end else if (bus.sample_edge) begin
                    shift_d = shifted;
                    if (count_q == LAST_BIT) begin
                        count_d = '0;
                        data_d  = shifted;
                        valid_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    // NOTE: the shift register is a plain flop bank, so it is reset like the rest
    // rather than left uninitialised as a RAM would be.
    always_ff @(posedge sys_clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = (state_q == ACTIVE);
endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: MSB-first and LSB-first instances driven in parallel,
// checked against a word-level model built from the transmitted bit lists.
module tb_serial_word_receiver;
    localparam int W = 8;

    typedef bit bitq_t[$];
    typedef logic [W-1:0] wordq_t[$];
    typedef struct {
        logic [W-1:0] word;
        int           cyc;
    } ev_t;

    logic sys_clk = 1'b0;
    logic n_reset = 1'b0;
    logic sample_edge = 1'b0;
    logic cs = 1'b1;
    logic data_in = 1'b0;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    ev_t v_msb[$];
    ev_t v_lsb[$];
    int  err_msb = 0;
    int  err_lsb = 0;
    int  overlap = 0;
    int  dbl_valid = 0;
    int  end_cycles[$];
    int  busy_drops = 0;
    logic prev_v_msb = 1'b0;
    logic prev_v_lsb = 1'b0;
    logic [W-1:0] last_msb = '0;
    logic [W-1:0] last_lsb = '0;

    serial_word_receiver_if #(.WORD_SIZE(W)) msb_if ();
    serial_word_receiver_if #(.WORD_SIZE(W)) lsb_if ();

    assign msb_if.sample_edge = sample_edge;
    assign msb_if.cs          = cs;
    assign msb_if.data_in     = data_in;
    assign lsb_if.sample_edge = sample_edge;
    assign lsb_if.cs          = cs;
    assign lsb_if.data_in     = data_in;

    serial_word_receiver #(.WORD_SIZE(W), .MSB_FIRST(1'b1), .CS_ACTIVE_LOW(1'b1)) dut_msb (
        .sys_clk (sys_clk),
        .n_reset (n_reset),
        .bus     (msb_if)
    );

    serial_word_receiver #(.WORD_SIZE(W), .MSB_FIRST(1'b0), .CS_ACTIVE_LOW(1'b1)) dut_lsb (
        .sys_clk (sys_clk),
        .n_reset (n_reset),
        .bus     (lsb_if)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event recorder: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge sys_clk) begin
        if (msb_if.data_valid) v_msb.push_back('{msb_if.data_out, cyc});
        if (lsb_if.data_valid) v_lsb.push_back('{lsb_if.data_out, cyc});
        if (msb_if.frame_err) err_msb++;
        if (lsb_if.frame_err) err_lsb++;
        if ((msb_if.data_valid && msb_if.frame_err) || (lsb_if.data_valid && lsb_if.frame_err)) overlap++;
        if ((msb_if.data_valid && prev_v_msb) || (lsb_if.data_valid && prev_v_lsb)) dbl_valid++;
        prev_v_msb = msb_if.data_valid;
        prev_v_lsb = lsb_if.data_valid;
    end

    // Reference model: every complete group of W transmitted bits forms one word.
    function automatic wordq_t model_words(input bit msb_first, input bitq_t bits);
        wordq_t q;
        for (int base = 0; base + W <= bits.size(); base += W) begin
            int unsigned v = 0;
            for (int i = 0; i < W; i++) begin
                if (msb_first) v = v * 2 + 32'(bits[base+i]);
                else           v = v + (32'(bits[base+i]) << i);
            end
            q.push_back(v[W-1:0]);
        end
        return q;
    endfunction

    function automatic bitq_t byte_bits(input logic [7:0] b);
        bitq_t q;
        for (int i = 7; i >= 0; i--) q.push_back(b[i]);
        return q;
    endfunction

    function automatic bitq_t rand_bits(input int n);
        bitq_t q;
        for (int i = 0; i < n; i++) q.push_back(1'($urandom));
        return q;
    endfunction

    task automatic clear_capture();
        v_msb.delete();
        v_lsb.delete();
        end_cycles.delete();
        err_msb = 0;
        err_lsb = 0;
        busy_drops = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            sample_edge = 1'b0;
        end
    endtask

    // Drives one frame: optional cs assertion cycle, one pulse every `gap` cycles, optional end.
    task automatic send_frame(input bitq_t bits, input int gap, input bit edge_at_assert,
                              input bit do_assert, input bit do_end, input bit edge_at_end);
        if (do_assert) begin
            @(negedge sys_clk);
            cs = 1'b0;
            sample_edge = edge_at_assert;
            data_in = 1'($urandom);
        end
        foreach (bits[i]) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge sys_clk);
                if (!msb_if.busy || !lsb_if.busy) busy_drops++;
                sample_edge = (g == gap - 1);
                data_in = (g == gap - 1) ? bits[i] : 1'($urandom);
            end
            if (i % W == W - 1) end_cycles.push_back(cyc);
        end
        if (do_end) begin
            @(negedge sys_clk);
            if (!msb_if.busy || !lsb_if.busy) busy_drops++;
            cs = 1'b1;
            sample_edge = edge_at_end;
            data_in = 1'($urandom);
            @(negedge sys_clk);
            sample_edge = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        cs = 1'b1;
        sample_edge = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_reset = 1'b1;
        clear_capture();
        repeat (5) begin
            @(negedge sys_clk);
            sample_edge = 1'b1;
            data_in = 1'b1;
            @(negedge sys_clk);
            sample_edge = 1'b0;
        end
        idle(3);
        tests_run++;
        if (v_msb.size() + v_lsb.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_valid: got %0d valid pulses, expected 0", v_msb.size() + v_lsb.size());
        end
        tests_run++;
        if ({msb_if.data_out, lsb_if.data_out} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h/%h, expected 00/00", msb_if.data_out, lsb_if.data_out);
        end
        tests_run++;
        if ({msb_if.busy, lsb_if.busy, msb_if.frame_err, lsb_if.frame_err} !== 4'b0000 || err_msb + err_lsb != 0) begin
            tests_failed++;
            $display("FAIL reset_busy_err: busy %b/%b errs %0d, expected idle", msb_if.busy, lsb_if.busy, err_msb + err_lsb);
        end
    endtask

    task automatic test_msb_word();
        bitq_t bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        wordq_t exp_m, exp_l;
        clear_capture();
        send_frame(bits, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        exp_m = model_words(1'b1, bits);
        exp_l = model_words(1'b0, bits);
        tests_run++;
        if (v_msb.size() != exp_m.size() || v_lsb.size() != exp_l.size()) begin
            tests_failed++;
            $display("FAIL msb_word_count: got %0d/%0d, expected %0d", v_msb.size(), v_lsb.size(), exp_m.size());
        end else begin
            foreach (exp_m[i]) begin
                tests_run++;
                if (v_msb[i].word !== exp_m[i] || v_lsb[i].word !== exp_l[i] || v_msb[i].cyc != end_cycles[i] + 1) begin
                    tests_failed++;
                    $display("FAIL msb_word[%0d]: got %h/%h at cyc %0d, expected %h/%h at cyc %0d",
                             i, v_msb[i].word, v_lsb[i].word, v_msb[i].cyc, exp_m[i], exp_l[i], end_cycles[i] + 1);
                end
            end
            last_msb = exp_m[exp_m.size()-1];
            last_lsb = exp_l[exp_l.size()-1];
        end
        tests_run++;
        if (busy_drops != 0 || msb_if.busy !== 1'b0 || err_msb != 0) begin
            tests_failed++;
            $display("FAIL msb_word_busy: busy drops %0d, final busy %b, errs %0d, expected 0/0/0",
                     busy_drops, msb_if.busy, err_msb);
        end
    endtask

    task automatic test_lsb_word();
        bitq_t b1 = '{1, 0, 1, 0, 0, 1, 0, 1};
        bitq_t b2 = '{1, 1, 0, 0, 0, 0, 0, 0};
        wordq_t e1 = model_words(1'b0, b1);
        wordq_t e2l = model_words(1'b0, b2);
        wordq_t e2m = model_words(1'b1, b2);
        clear_capture();
        send_frame(b1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        tests_run++;
        if (lsb_if.data_out !== e1[0]) begin
            tests_failed++;
            $display("FAIL lsb_palindrome: got %h, expected %h", lsb_if.data_out, e1[0]);
        end
        send_frame(b2, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        tests_run++;
        if (lsb_if.data_out !== e2l[0] || msb_if.data_out !== e2m[0] || v_lsb.size() != 2) begin
            tests_failed++;
            $display("FAIL lsb_second: got lsb %h msb %h (%0d words), expected %h/%h (2 words)",
                     lsb_if.data_out, msb_if.data_out, v_lsb.size(), e2l[0], e2m[0]);
        end
        last_msb = e2m[0];
        last_lsb = e2l[0];
    endtask

    task automatic test_back_to_back();
        bitq_t bits = byte_bits(8'h3C);
        wordq_t exp_m, exp_l;
        bits = {bits, byte_bits(8'hFF)};
        exp_m = model_words(1'b1, bits);
        exp_l = model_words(1'b0, bits);
        clear_capture();
        send_frame(bits, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if (v_msb.size() != exp_m.size() || v_lsb.size() != exp_l.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d/%0d, expected %0d", v_msb.size(), v_lsb.size(), exp_m.size());
        end else begin
            foreach (exp_m[i]) begin
                tests_run++;
                if (v_msb[i].word !== exp_m[i] || v_lsb[i].word !== exp_l[i] || v_msb[i].cyc != end_cycles[i] + 1) begin
                    tests_failed++;
                    $display("FAIL b2b_word[%0d]: got %h/%h at cyc %0d, expected %h/%h at cyc %0d",
                             i, v_msb[i].word, v_lsb[i].word, v_msb[i].cyc, exp_m[i], exp_l[i], end_cycles[i] + 1);
                end
            end
            last_msb = exp_m[exp_m.size()-1];
            last_lsb = exp_l[exp_l.size()-1];
        end
        tests_run++;
        if (err_msb + err_lsb != 0) begin
            tests_failed++;
            $display("FAIL b2b_frame_err: got %0d error pulses, expected 0", err_msb + err_lsb);
        end
    endtask

    task automatic test_partial_frame();
        bitq_t bits = rand_bits(3);
        wordq_t exp_m, exp_l;
        clear_capture();
        send_frame(bits, 2, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);
        tests_run++;
        if (err_msb != 1 || err_lsb != 1 || v_msb.size() + v_lsb.size() != 0) begin
            tests_failed++;
            $display("FAIL partial_err: got errs %0d/%0d valids %0d, expected 1/1 and 0",
                     err_msb, err_lsb, v_msb.size() + v_lsb.size());
        end
        tests_run++;
        if (msb_if.data_out !== last_msb || lsb_if.data_out !== last_lsb || msb_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_hold: got %h/%h busy %b, expected %h/%h busy 0",
                     msb_if.data_out, lsb_if.data_out, msb_if.busy, last_msb, last_lsb);
        end
        bits = byte_bits(8'h81);
        exp_m = model_words(1'b1, bits);
        exp_l = model_words(1'b0, bits);
        clear_capture();
        send_frame(bits, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if (v_msb.size() != 1 || msb_if.data_out !== exp_m[0] || lsb_if.data_out !== exp_l[0] || err_msb != 0) begin
            tests_failed++;
            $display("FAIL partial_restart: got %h/%h (%0d words, %0d errs), expected %h/%h (1 word, 0 errs)",
                     msb_if.data_out, lsb_if.data_out, v_msb.size(), err_msb, exp_m[0], exp_l[0]);
        end
        last_msb = exp_m[0];
        last_lsb = exp_l[0];
    endtask

    task automatic test_reset_mid_word();
        bitq_t bits = byte_bits(8'h5A);
        wordq_t exp_m = model_words(1'b1, bits);
        wordq_t exp_l = model_words(1'b0, bits);
        clear_capture();
        send_frame(rand_bits(5), 2, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge sys_clk);
        n_reset = 1'b0;
        sample_edge = 1'b1;
        data_in = 1'b1;
        @(negedge sys_clk);
        tests_run++;
        if ({msb_if.data_out, lsb_if.data_out} !== 16'h0000 ||
            {msb_if.data_valid, msb_if.frame_err, msb_if.busy, lsb_if.busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %h/%h valid %b err %b busy %b, expected all zero",
                     msb_if.data_out, lsb_if.data_out, msb_if.data_valid, msb_if.frame_err, msb_if.busy);
        end
        last_msb = '0;
        last_lsb = '0;
        // cs stays active: this cycle is the IDLE->ACTIVE cycle, and its strobe must be ignored.
        n_reset = 1'b1;
        sample_edge = 1'b1;
        data_in = 1'b1;
        send_frame(bits, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if (v_msb.size() != 1 || v_lsb.size() != 1 || msb_if.data_out !== exp_m[0] ||
            lsb_if.data_out !== exp_l[0] || err_msb + err_lsb != 0) begin
            tests_failed++;
            $display("FAIL midreset_next: got %h/%h (%0d words, %0d errs), expected %h/%h (1 word, 0 errs)",
                     msb_if.data_out, lsb_if.data_out, v_msb.size(), err_msb + err_lsb, exp_m[0], exp_l[0]);
        end
        last_msb = exp_m[0];
        last_lsb = exp_l[0];
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int len = $urandom_range(1, 20);
            int gap = $urandom_range(1, 4);
            bitq_t bits = rand_bits(len);
            wordq_t exp_m = model_words(1'b1, bits);
            wordq_t exp_l = model_words(1'b0, bits);
            int exp_err = (len % W != 0) ? 1 : 0;
            clear_capture();
            send_frame(bits, gap, 1'($urandom), 1'b1, 1'b1, 1'($urandom));
            idle(2);
            if (exp_m.size() != 0) begin
                last_msb = exp_m[exp_m.size()-1];
                last_lsb = exp_l[exp_l.size()-1];
            end
            tests_run++;
            if (v_msb.size() != exp_m.size() || v_lsb.size() != exp_l.size() ||
                err_msb != exp_err || err_lsb != exp_err) begin
                tests_failed++;
                $display("FAIL rand%0d_counts: got words %0d/%0d errs %0d/%0d, expected words %0d errs %0d",
                         f, v_msb.size(), v_lsb.size(), err_msb, err_lsb, exp_m.size(), exp_err);
            end else begin
                foreach (exp_m[i]) begin
                    tests_run++;
                    if (v_msb[i].word !== exp_m[i] || v_lsb[i].word !== exp_l[i] || v_msb[i].cyc != end_cycles[i] + 1) begin
                        tests_failed++;
                        $display("FAIL rand%0d_word[%0d]: got %h/%h at cyc %0d, expected %h/%h at cyc %0d",
                                 f, i, v_msb[i].word, v_lsb[i].word, v_msb[i].cyc, exp_m[i], exp_l[i], end_cycles[i] + 1);
                    end
                end
            end
            tests_run++;
            if (msb_if.data_out !== last_msb || lsb_if.data_out !== last_lsb || busy_drops != 0) begin
                tests_failed++;
                $display("FAIL rand%0d_hold: got %h/%h busy drops %0d, expected %h/%h and 0",
                         f, msb_if.data_out, lsb_if.data_out, busy_drops, last_msb, last_lsb);
            end
        end
    endtask

    task automatic test_invariants();
        tests_run++;
        if (overlap != 0 || dbl_valid != 0) begin
            tests_failed++;
            $display("FAIL invariants: got %0d valid/err overlaps and %0d double valids, expected 0/0",
                     overlap, dbl_valid);
        end
    endtask

    initial begin
        test_reset();
        test_msb_word();
        test_lsb_word();
        test_back_to_back();
        test_partial_frame();
        test_reset_mid_word();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
